hack_cpu_ctrl: RTL and testbench

//  Control and register stage for the 16-bit Hack ALU: fetches instructions, holds the A, D and PC registers, and decodes C-instructions into ALU controls.

---
 rtl/hack_pkg.sv | 32 +++
 rtl/hack_cpu_ctrl_if.sv | 35 +++
 rtl/hack_jump_eval.sv | 13 +
 rtl/hack_cpu_ctrl.sv | 104 ++++++++++
 tb/tb_hack_cpu_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared encodings for the Hack control stage: FSM states, IR field positions,
// destination and jump bit positions.
package hack_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Instruction register field positions
  localparam int IR_I    = 15;
  localparam int IR_A    = 12;
  localparam int IR_C_HI = 11;
  localparam int IR_C_LO = 6;
  localparam int IR_D_HI = 5;
  localparam int IR_D_LO = 3;
  localparam int IR_J_HI = 2;
  localparam int IR_J_LO = 0;

  // Destination bits within the IR
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;

  // Jump bits within the 3-bit jump field
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Bus bundle between the Hack control stage and its ROM, RAM and ALU.
// master = control stage, slave = ROM/RAM/ALU side.
interface hack_cpu_ctrl_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic [14:0] pc;
  logic [15:0] inM;
  logic        mem_ready;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx;
  logic        alu_nx;
  logic        alu_zy;
  logic        alu_ny;
  logic        alu_f;
  logic        alu_no;
  logic [15:0] alu_o;
  logic        alu_zr;
  logic        alu_ng;

  modport master (
    input  instr, instr_valid, inM, mem_ready, alu_o, alu_zr, alu_ng,
    output pc, outM, writeM, addressM, alu_x, alu_y,
    output alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
  );

  modport slave (
    output instr, instr_valid, inM, mem_ready, alu_o, alu_zr, alu_ng,
    input  pc, outM, writeM, addressM, alu_x, alu_y,
    input  alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
  );
endinterface

// File: rtl/hack_jump_eval.sv
// Jump condition evaluator: combines the 3-bit jump field with the ALU flags.
module hack_jump_eval
  import hack_pkg::*;
(
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       jmp
);

  assign jmp = (j[JMP_LT] & ng) | (j[JMP_EQ] & zr) | (j[JMP_GT] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack control/register stage: fetch, A/D/PC registers, C-instruction decode,
// writeback, RAM write handshake and jumps. Optional HALT via HACK_CTRL_HALT_EN.
module hack_cpu_ctrl
  import hack_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  hack_cpu_ctrl_if.master       bus,
  output logic                  halted
);

  state_t      state;
  logic [15:0] ir;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [14:0] pc;
  logic        write_m;

  logic        is_c;
  logic        mem_access;
  logic        ctrl_en;
  logic        jmp;
  logic        do_commit;
  logic        halt_hit;
  logic [14:0] pc_inc;
  logic [14:0] pc_commit;

  assign is_c       = ir[IR_I];
  assign mem_access = ir[IR_A] | ir[DEST_M];
  assign ctrl_en    = is_c && ((state == EXEC) || (state == MEM));

  assign {bus.alu_zx, bus.alu_nx, bus.alu_zy,
          bus.alu_ny, bus.alu_f,  bus.alu_no} = ctrl_en ? ir[IR_C_HI:IR_C_LO] : 6'b0;

  assign bus.alu_x    = d_reg;
  assign bus.alu_y    = ir[IR_A] ? bus.inM : a_reg;
  assign bus.outM     = bus.alu_o;
  assign bus.writeM   = write_m;
  assign bus.addressM = a_reg[14:0];
  assign bus.pc       = pc;

  hack_jump_eval u_jump (
    .j   (ir[IR_J_HI:IR_J_LO]),
    .zr  (bus.alu_zr),
    .ng  (bus.alu_ng),
    .jmp (jmp)
  );

  // Jump target is the pre-commit A, even when this instruction also writes A
  assign pc_inc    = pc + 15'd1;
  assign pc_commit = jmp ? a_reg[14:0] : pc_inc;

  assign do_commit = is_c && (((state == EXEC) && !mem_access) ||
                              ((state == MEM) && bus.mem_ready));

`ifdef HACK_CTRL_HALT_EN
  assign halt_hit = jmp && (a_reg[14:0] == pc);
  assign halted   = (state == HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      ir      <= 16'd0;
      a_reg   <= 16'd0;
      d_reg   <= 16'd0;
      pc      <= 15'd0;
      write_m <= 1'b0;
    end else if (do_commit) begin
      if (ir[DEST_A]) a_reg <= bus.alu_o;
      if (ir[DEST_D]) d_reg <= bus.alu_o;
      pc      <= pc_commit;
      write_m <= 1'b0;
      state   <= halt_hit ? HALT : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!is_c) begin
            a_reg <= {1'b0, ir[14:0]};
            pc    <= pc_inc;
            state <= FETCH;
          end else begin
            // Only memory-touching C-instructions reach here; commit waits for RAM
            write_m <= ir[DEST_M];
            state   <= MEM;
          end
        end
        MEM:     state <= MEM;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed self-checking bench for hack_cpu_ctrl; models ROM, RAM and the Hack ALU.
module tb_hack_cpu_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic halted;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] rom [0:32767];
  logic [15:0] ax, ay, ao;
  logic [5:0]  ctrls;

  hack_cpu_ctrl_if bus ();

  hack_cpu_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .halted (halted)
  );

  always #5 clk = ~clk;

  assign bus.instr = rom[bus.pc];
  assign ctrls = {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no};

  // Reference Hack ALU
  always_comb begin
    ax = bus.alu_zx ? 16'd0 : bus.alu_x;
    ax = bus.alu_nx ? ~ax : ax;
    ay = bus.alu_zy ? 16'd0 : bus.alu_y;
    ay = bus.alu_ny ? ~ay : ay;
    ao = bus.alu_f ? (ax + ay) : (ax & ay);
    ao = bus.alu_no ? ~ao : ao;
    bus.alu_o  = ao;
    bus.alu_zr = (ao == 16'd0);
    bus.alu_ng = ao[15];
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
  endtask

  task automatic apply_reset();
    rst_n           = 1'b0;
    bus.instr_valid = 1'b1;
    bus.mem_ready   = 1'b0;
    bus.inM         = 16'h0000;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_rom();
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.inM         = 16'h0000;
    step(2);
    n_cmp++; if (bus.pc !== 15'd0) begin n_bad++; $display("FAIL reset_pc got %h want 0000", bus.pc); end
    n_cmp++; if (bus.writeM !== 1'b0) begin n_bad++; $display("FAIL reset_writeM got %b want 0", bus.writeM); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %b want 0", halted); end
    n_cmp++; if (bus.addressM !== 15'd0) begin n_bad++; $display("FAIL reset_addrM got %h want 0000", bus.addressM); end
    n_cmp++; if (bus.alu_x !== 16'd0) begin n_bad++; $display("FAIL reset_D got %h want 0000", bus.alu_x); end
    n_cmp++; if (ctrls !== 6'b0) begin n_bad++; $display("FAIL reset_ctrls got %b want 000000", ctrls); end
    // FETCH must stall without instr_valid
    rst_n = 1'b1;
    rom[0] = 16'h0009;
    step(3);
    n_cmp++; if (bus.pc !== 15'd0) begin n_bad++; $display("FAIL stall_pc got %h want 0000", bus.pc); end
    bus.instr_valid = 1'b1;
    step(2);
    n_cmp++; if (bus.pc !== 15'd1) begin n_bad++; $display("FAIL stall_resume_pc got %h want 0001", bus.pc); end
    n_cmp++; if (bus.addressM !== 15'd9) begin n_bad++; $display("FAIL stall_resume_A got %h want 0009", bus.addressM); end
  endtask

  task automatic test_reset_in_mem();
    clear_rom();
    rom[0] = 16'h000C; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE7C8;
    apply_reset();
    step(8);
    n_cmp++; if (bus.writeM !== 1'b1) begin n_bad++; $display("FAIL rmem_pre_writeM got %b want 1", bus.writeM); end
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    step(2);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    n_cmp++; if (bus.pc !== 15'd0) begin n_bad++; $display("FAIL rmem_pc got %h want 0000", bus.pc); end
    n_cmp++; if (bus.writeM !== 1'b0) begin n_bad++; $display("FAIL rmem_writeM got %b want 0", bus.writeM); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rmem_halted got %b want 0", halted); end
    n_cmp++; if (bus.alu_x !== 16'd0) begin n_bad++; $display("FAIL rmem_D got %h want 0000", bus.alu_x); end
    step(2);
    n_cmp++; if (bus.pc !== 15'd1 || bus.addressM !== 15'd12) begin
      n_bad++; $display("FAIL rmem_refetch got pc=%h A=%h want pc=0001 A=000c", bus.pc, bus.addressM);
    end
  endtask

  task automatic test_d_eq_a();
    clear_rom();
    rom[0] = 16'h000C; rom[1] = 16'hEC10;
    apply_reset();
    step(3);
    n_cmp++; if (ctrls !== 6'b110000) begin n_bad++; $display("FAIL dea_ctrls got %b want 110000", ctrls); end
    step(1);
    n_cmp++; if (bus.alu_x !== 16'd12) begin n_bad++; $display("FAIL dea_D got %h want 000c", bus.alu_x); end
    n_cmp++; if (bus.pc !== 15'd2) begin n_bad++; $display("FAIL dea_pc got %h want 0002", bus.pc); end
    n_cmp++; if (ctrls !== 6'b0) begin n_bad++; $display("FAIL dea_ctrls_fetch got %b want 000000", ctrls); end
  endtask

  task automatic test_mem_write();
    clear_rom();
    rom[0] = 16'h000C; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE7C8;
    apply_reset();
    step(8);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus.writeM !== 1'b1) begin n_bad++; $display("FAIL memw_writeM[%0d] got %b want 1", k, bus.writeM); end
      n_cmp++; if (bus.addressM !== 15'd100) begin n_bad++; $display("FAIL memw_addr[%0d] got %h want 0064", k, bus.addressM); end
      n_cmp++; if (bus.outM !== 16'd13) begin n_bad++; $display("FAIL memw_outM[%0d] got %h want 000d", k, bus.outM); end
      n_cmp++; if (bus.pc !== 15'd3) begin n_bad++; $display("FAIL memw_pc[%0d] got %h want 0003", k, bus.pc); end
      if (k == 2) bus.mem_ready = 1'b1;
      step(1);
    end
    bus.mem_ready = 1'b0;
    n_cmp++; if (bus.writeM !== 1'b0) begin n_bad++; $display("FAIL memw_done_writeM got %b want 0", bus.writeM); end
    n_cmp++; if (bus.pc !== 15'd4) begin n_bad++; $display("FAIL memw_done_pc got %h want 0004", bus.pc); end
    n_cmp++; if (bus.alu_x !== 16'd12) begin n_bad++; $display("FAIL memw_done_D got %h want 000c", bus.alu_x); end
  endtask

  task automatic test_jump();
    clear_rom();
    rom[0] = 16'h0014; rom[1] = 16'hE302;
    apply_reset();
    step(4);
    n_cmp++; if (bus.pc !== 15'd20) begin n_bad++; $display("FAIL jeq_taken_pc got %h want 0014", bus.pc); end
    clear_rom();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0014; rom[3] = 16'hE302;
    apply_reset();
    step(8);
    n_cmp++; if (bus.pc !== 15'd4) begin n_bad++; $display("FAIL jeq_not_taken_pc got %h want 0004", bus.pc); end
    // A=D;JEQ with D=0: jump must use A before it is overwritten
    clear_rom();
    rom[0] = 16'h0014; rom[1] = 16'hE322;
    apply_reset();
    step(4);
    n_cmp++; if (bus.pc !== 15'd20) begin n_bad++; $display("FAIL jeq_destA_pc got %h want 0014", bus.pc); end
    n_cmp++; if (bus.addressM !== 15'd0) begin n_bad++; $display("FAIL jeq_destA_A got %h want 0000", bus.addressM); end
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'h0003;
    apply_reset();
    step(4);
    n_cmp++; if (bus.pc !== 15'h7FFF) begin n_bad++; $display("FAIL wrap_jmp_pc got %h want 7fff", bus.pc); end
    step(2);
    n_cmp++; if (bus.pc !== 15'h0000) begin n_bad++; $display("FAIL wrap_pc got %h want 0000", bus.pc); end
    n_cmp++; if (bus.addressM !== 15'd3) begin n_bad++; $display("FAIL wrap_A got %h want 0003", bus.addressM); end
  endtask

  task automatic test_self_jump();
    clear_rom();
    rom[0] = 16'h0005; rom[1] = 16'hEA87; rom[5] = 16'hEA87; rom[6] = 16'h0001;
    apply_reset();
    step(4);
    n_cmp++; if (bus.pc !== 15'd5) begin n_bad++; $display("FAIL self_pre_pc got %h want 0005", bus.pc); end
    step(2);
`ifdef HACK_CTRL_HALT_EN
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL self_halted got %b want 1", halted); end
    for (int k = 0; k < 3; k++) begin
      bus.instr_valid = k[0];
      step(2);
      n_cmp++; if (bus.pc !== 15'd5 || halted !== 1'b1 || ctrls !== 6'b0) begin
        n_bad++; $display("FAIL self_hold[%0d] got pc=%h halted=%b ctrls=%b want pc=0005 halted=1 ctrls=000000", k, bus.pc, halted, ctrls);
      end
    end
    bus.instr_valid = 1'b1;
`else
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus.pc !== 15'd5 || halted !== 1'b0) begin
        n_bad++; $display("FAIL self_loop_end[%0d] got pc=%h halted=%b want pc=0005 halted=0", k, bus.pc, halted);
      end
      step(1);
      n_cmp++; if (ctrls !== 6'b101010) begin n_bad++; $display("FAIL self_loop_exec[%0d] got %b want 101010", k, ctrls); end
      step(1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_in_mem();
    test_d_eq_a();
    test_mem_write();
    test_jump();
    test_pc_wrap();
    test_self_jump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
